lsu_bus_master: RTL and testbench

- Load/store initiator between the core's memory stage and the word-organised data memory.
- Takes one byte-addressed load or store per request and drives word-aligned requests on the memory side with byte enables.
- Splits accesses that cross a word boundary into two memory transactions.
- Returns sign- or zero-extended load data to the core with a valid pulse.

---
 rtl/lsu_bus_master.sv | 231 +++++++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// Load/store initiator: turns one byte-addressed core access into one or two
// word-aligned memory transactions and returns extended load data.
module lsu_bus_master #(
    parameter int unsigned width = 32,
    parameter int unsigned lanes = width / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_func3,
    input  logic [width-1:0] req_addr,
    input  logic [width-1:0] req_wdata,
    output logic             resp_valid,
    output logic [width-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [lanes-1:0] mem_be,
    output logic [width-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [width-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         func3_q, func3_d;
    logic [1:0]         off_q, off_d;
    logic [width-1:0]   wdata_q, wdata_d;
    logic               split_q, split_d;
    logic [width-1:0]   w0_q, w0_d;

    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [width-1:0]   mem_addr_q, mem_addr_d;
    logic [lanes-1:0]   mem_be_q, mem_be_d;
    logic [width-1:0]   mem_wdata_q, mem_wdata_d;
    logic               resp_valid_q, resp_valid_d;
    logic [width-1:0]   resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    logic [1:0]         src_size;
    logic [1:0]         src_off;
    logic [width-1:0]   src_wdata;
    logic [2*lanes-1:0] size_mask;
    logic [3:0]         size_bytes;
    logic [2*lanes-1:0] be_shift;
    logic [2*width-1:0] wd_shift;
    logic               split_now;
    logic               legal;
    logic [width-1:0]   rd_hi, rd_lo, raw;
    logic [width-1:0]   load_data;

    // Lane placement uses the live request in IDLE and the latched one after;
    // the upper halves of the shifted mask/data form the second access.
    always_comb begin
        if (state_q == IDLE) begin
            src_size  = req_func3[1:0];
            src_off   = req_addr[1:0];
            src_wdata = req_wdata;
        end else begin
            src_size  = func3_q[1:0];
            src_off   = off_q;
            src_wdata = wdata_q;
        end
        case (src_size)
            2'b00: begin
                size_mask  = (2*lanes)'(1);
                size_bytes = 4'd1;
            end
            2'b01: begin
                size_mask  = (2*lanes)'(3);
                size_bytes = 4'd2;
            end
            default: begin
                size_mask  = (2*lanes)'(15);
                size_bytes = 4'd4;
            end
        endcase
        be_shift  = size_mask << src_off;
        wd_shift  = {{width{1'b0}}, src_wdata} << {src_off, 3'b000};
        split_now = ({2'b00, src_off} + size_bytes) > 4'd4;
    end

    always_comb begin
        case (req_func3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_we;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        if (state_q == ACC1) begin
            rd_hi = mem_rdata;
            rd_lo = w0_q;
        end else begin
            rd_hi = '0;
            rd_lo = mem_rdata;
        end
        raw = width'({rd_hi, rd_lo} >> {off_q, 3'b000});
        case (func3_q)
            3'b000:  load_data = {{(width-8){raw[7]}}, raw[7:0]};
            3'b001:  load_data = {{(width-16){raw[15]}}, raw[15:0]};
            3'b010:  load_data = raw;
            3'b100:  load_data = {{(width-8){1'b0}}, raw[7:0]};
            3'b101:  load_data = {{(width-16){1'b0}}, raw[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        func3_d      = func3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        split_d      = split_q;
        w0_d         = w0_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    func3_d = req_func3;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    split_d = split_now;
                    if (!legal) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACC0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[width-1:2], 2'b00};
                        mem_be_d    = be_shift[lanes-1:0];
                        mem_wdata_d = wd_shift[width-1:0];
                    end
                end
            end
            ACC0: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        w0_d = mem_rdata;
                    end
                    if (split_q) begin
                        state_d     = ACC1;
                        mem_addr_d  = mem_addr_q + width'(lanes);
                        mem_be_d    = be_shift[2*lanes-1:lanes];
                        mem_wdata_d = wd_shift[2*width-1:width];
                    end else begin
                        state_d      = RESP;
                        mem_req_d    = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = we_q ? '0 : load_data;
                    end
                end
            end
            ACC1: begin
                if (mem_ack) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : load_data;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            func3_q      <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            split_q      <= 1'b0;
            w0_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            func3_q      <= func3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            split_q      <= split_d;
            w0_q         <= w0_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: byte-level memory responder plus a byte-wise
// reference model of accesses, lane placement, extension and latency.
module tb_lsu_bus_master;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] bmem [bit [31:0]];
    acc_t       acc_q[$];
    bit         hold_ack = 1'b0;
    int         max_wait = 0;
    int         stall_cycles = 0;

    always #5 clk = ~clk;

    lsu_bus_master #(.width(32), .lanes(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input bit [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5C;
    endfunction

    task automatic set_word(input bit [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bmem[a + 32'(i)] = w[8*i +: 8];
    endtask

    // Memory responder: random wait states, spurious acks while idle,
    // and a stability check on every stall cycle.
    logic        prev_stall = 1'b0, ack_prev = 1'b0, active = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;
    logic        p_we;
    int          wait_left = 0;

    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (prev_stall) begin
                check("stall_addr", mem_addr, p_addr);
                check("stall_be", {28'b0, mem_be}, {28'b0, p_be});
                check("stall_wdata", mem_wdata, p_wdata);
                check("stall_we", {31'b0, mem_we}, {31'b0, p_we});
            end
            if (!active || ack_prev) begin
                wait_left = (max_wait > 0) ? $urandom_range(0, max_wait) : 0;
                active = 1'b1;
            end
            if (!hold_ack && wait_left == 0) begin
                acc_t a;
                mem_ack = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    mem_rdata[8*l +: 8] = rd_byte(mem_addr + 32'(l));
                    if (mem_we && mem_be[l]) bmem[mem_addr + 32'(l)] = mem_wdata[8*l +: 8];
                end
                a.addr = mem_addr; a.be = mem_be; a.wdata = mem_wdata; a.we = mem_we;
                acc_q.push_back(a);
                prev_stall = 1'b0;
                ack_prev = 1'b1;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                if (wait_left > 0) wait_left--;
                stall_cycles++;
                prev_stall = 1'b1;
                ack_prev = 1'b0;
                p_addr = mem_addr; p_be = mem_be; p_wdata = mem_wdata; p_we = mem_we;
            end
        end else begin
            active = 1'b0;
            ack_prev = 1'b0;
            prev_stall = 1'b0;
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag,
                          output logic [31:0] rd, output int lat);
        acc_t exp_q[$];
        acc_t e;
        int size, n, exp_lat;
        bit legal, got;
        logic [31:0] v, exp_rd, m;
        bit [31:0] a, wa;
        int l;

        legal = we ? (f3 <= 3'b010) : (f3 <= 3'b010 || f3 == 3'b100 || f3 == 3'b101);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        v = '0;
        if (legal) begin
            for (int i = 0; i < size; i++) begin
                a = addr + 32'(i);
                wa = {a[31:2], 2'b00};
                l = int'(a[1:0]);
                if (exp_q.size() == 0 || exp_q[exp_q.size()-1].addr != wa) begin
                    e = '0; e.addr = wa; e.we = we;
                    exp_q.push_back(e);
                end
                e = exp_q[exp_q.size()-1];
                e.be[l] = 1'b1;
                e.wdata[8*l +: 8] = wdata[8*i +: 8];
                exp_q[exp_q.size()-1] = e;
                v[8*i +: 8] = rd_byte(a);
            end
        end
        if (!legal || we) exp_rd = '0;
        else if (size == 1) exp_rd = f3[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        else if (size == 2) exp_rd = f3[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        else exp_rd = v;

        @(negedge clk);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
        acc_q.delete();
        stall_cycles = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0; got = 0;
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            if (resp_valid === 1'b1) got = 1;
        end
        exp_lat = legal ? 1 + exp_q.size() + stall_cycles : 1;
        lat = got ? n : -1;
        rd = resp_rdata;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_err"}, {31'b0, resp_err}, {31'b0, !legal});
        check({tag, "_nacc"}, 32'(acc_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            check($sformatf("%s_a%0d_addr", tag, i), acc_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_a%0d_be", tag, i), {28'b0, acc_q[i].be}, {28'b0, exp_q[i].be});
            check($sformatf("%s_a%0d_we", tag, i), {31'b0, acc_q[i].we}, {31'b0, exp_q[i].we});
            if (we) begin
                for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{exp_q[i].be[b]}};
                check($sformatf("%s_a%0d_wdata", tag, i), acc_q[i].wdata & m, exp_q[i].wdata);
            end
        end
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat;
        logic        we_r;
        logic [2:0]  f_r;
        logic [31:0] a_r;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = '0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        set_word(32'h100, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, "lw", rd, lat);
        check("lw_data_const", rd, 32'hDEADBEEF);
        check("lw_lat_const", 32'(lat), 32'd2);
        check("lw_be_const", {28'b0, acc_q[0].be}, 32'h0000000F);

        set_word(32'h100, 32'h80112233);
        do_req(1'b0, 3'b000, 32'h103, 32'h0, "lb", rd, lat);
        check("lb_data_const", rd, 32'hFFFFFF80);
        check("lb_be_const", {28'b0, acc_q[0].be}, 32'h00000008);
        do_req(1'b0, 3'b100, 32'h103, 32'h0, "lbu", rd, lat);
        check("lbu_data_const", rd, 32'h00000080);
        check("lbu_be_const", {28'b0, acc_q[0].be}, 32'h00000008);

        do_req(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, "sw_split", rd, lat);
        check("sw_a0_addr_const", acc_q[0].addr, 32'h100);
        check("sw_a0_be_const", {28'b0, acc_q[0].be}, 32'h0000000C);
        check("sw_a0_wdata_const", acc_q[0].wdata, 32'hCCDD0000);
        check("sw_a1_addr_const", acc_q[1].addr, 32'h104);
        check("sw_a1_be_const", {28'b0, acc_q[1].be}, 32'h00000003);
        check("sw_a1_wdata_const", acc_q[1].wdata, 32'h0000AABB);
        check("sw_lat_const", 32'(lat), 32'd3);

        set_word(32'hFFFFFFFC, 32'h7F000000);
        set_word(32'h0, 32'h00000080);
        do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, "lh_wrap", rd, lat);
        check("lh_wrap_a1_const", acc_q[1].addr, 32'h0);
        check("lh_wrap_data_const", rd, 32'hFFFF807F);

        do_req(1'b0, 3'b011, 32'h40, 32'h0, "ill", rd, lat);
        check("ill_lat_const", 32'(lat), 32'd1);

        // Reset while the first access is stalled.
        set_word(32'h200, 32'h12345678);
        hold_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_req_held", {31'b0, mem_req}, 32'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        hold_ack = 1'b0;
        check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("rst_mid_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        do_req(1'b0, 3'b010, 32'h200, 32'h0, "after_rst", rd, lat);
        check("after_rst_data_const", rd, 32'h12345678);

        max_wait = 2;
        for (int k = 0; k < 150; k++) begin
            we_r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f_r = 3'($urandom_range(0, 7));
            else if (we_r) f_r = 3'($urandom_range(0, 2));
            else begin
                f_r = 3'($urandom_range(0, 4));
                if (f_r == 3'b011) f_r = 3'b101;
            end
            if ($urandom_range(0, 7) == 0) a_r = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else a_r = 32'($urandom_range(0, 47));
            do_req(we_r, f_r, a_r, $urandom, $sformatf("rnd%0d", k), rd, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
